adder_accumulator_n: RTL and testbench

//  Parametrised adder/accumulator: operand register (Register_1) loaded from data_in,

---
 rtl/adder_accumulator_n.sv | 96 +++++++++
 tb/tb_adder_accumulator_n.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulator_n.sv
// Parametrised adder/accumulator with sticky flags and registered output mux.
// Optional feature macro: ADDACC_SATURATE_EN (saturating accumulator).
module adder_accumulator_n #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              add,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        output_sel,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cnt_carry_q, cnt_carry_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [ACC_W:0]      sum;
    logic [4*DATA_W-1:0] acc_ext;

    assign sum = {1'b0, acc_q} + {{(ACC_W-DATA_W+1){1'b0}}, operand_q};

    always_comb begin
        operand_d   = operand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cnt_carry_d = cnt_carry_q;
        ovf_d       = ovf_q;
        if (load) begin
            operand_d = data_in;
        end
        // clear wins over add; the add sees the operand from before any load
        if (clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            cnt_carry_d = 1'b0;
            ovf_d       = 1'b0;
        end else if (add) begin
`ifdef ADDACC_SATURATE_EN
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            cnt_d = cnt_q + CNT_W'(1);
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
            if (cnt_q == {CNT_W{1'b1}}) begin
                cnt_carry_d = 1'b1;
            end
        end
    end

    always_comb begin
        acc_ext              = '0;
        acc_ext[ACC_W-1:0]   = acc_q;
        data_out_d           = '0;
        case (output_sel)
            3'd0: data_out_d = acc_ext[0*DATA_W +: DATA_W];
            3'd1: data_out_d = acc_ext[1*DATA_W +: DATA_W];
            3'd2: data_out_d = acc_ext[2*DATA_W +: DATA_W];
            3'd3: data_out_d = acc_ext[3*DATA_W +: DATA_W];
            3'd4: data_out_d = operand_q;
            3'd5: data_out_d[CNT_W-1:0] = cnt_q;
            3'd6: data_out_d[1:0] = {ovf_q, cnt_carry_q};
            3'd7: data_out_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            operand_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            cnt_carry_q <= 1'b0;
            ovf_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            operand_q   <= operand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cnt_carry_q <= cnt_carry_d;
            ovf_q       <= ovf_d;
            data_out_q  <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_adder_accumulator_n.sv
// Self-checking bench for adder_accumulator_n (DATA_W=8, ACC_W=16, CNT_W=8).
// Randomized and directed stimulus against an arithmetic reference model.
module tb_adder_accumulator_n;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 8;
    localparam longint ACC_MOD = 64'd1 << AW;
    localparam int CNT_MOD = 1 << CW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic          add = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [2:0]    output_sel = '0;
    logic [DW-1:0] data_out;

    int tests_run = 0;
    int failed = 0;

    longint m_acc;
    int     m_op;
    int     m_cnt;
    bit     m_ovf;
    bit     m_cc;

    adder_accumulator_n #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .load(load),
        .add(add),
        .clear(clear),
        .data_in(data_in),
        .output_sel(output_sel),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    task automatic m_reset();
        m_acc = 0; m_op = 0; m_cnt = 0; m_ovf = 0; m_cc = 0;
    endtask

    task automatic m_step(input bit l, input bit a, input bit c, input int d);
        longint s;
        if (c) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0; m_cc = 0;
        end else if (a) begin
            s = m_acc + longint'(m_op);
            if (s >= ACC_MOD) begin
                m_ovf = 1;
`ifdef ADDACC_SATURATE_EN
                s = ACC_MOD - 1;
`else
                s = s - ACC_MOD;
`endif
            end
            m_acc = s;
            m_cnt = m_cnt + 1;
            if (m_cnt == CNT_MOD) begin
                m_cnt = 0;
                m_cc = 1;
            end
        end
        if (l) m_op = d;
    endtask

    function automatic logic [DW-1:0] m_out(input int sel);
        case (sel)
            0, 1, 2, 3: return DW'((m_acc >> (sel * DW)) % 256);
            4: return DW'(m_op);
            5: return DW'(m_cnt);
            6: return DW'({m_ovf, m_cc});
            default: return '0;
        endcase
    endfunction

    task automatic do_op(input bit l, input bit a, input bit c, input int d);
        load = l; add = a; clear = c; data_in = DW'(d);
        @(posedge clock); #1;
        m_step(l, a, c, d);
        load = 0; add = 0; clear = 0;
    endtask

    task automatic read_sel(input int sel, output logic [DW-1:0] v);
        load = 0; add = 0; clear = 0; output_sel = 3'(sel);
        @(posedge clock); #1;
        v = data_out;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        reset_n = 0;
        m_reset();
        #1;
        for (int s = 0; s < 8; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== 8'h00) begin
                failed++;
                $display("FAIL reset_sel%0d got=%h exp=00", s, v);
            end
        end
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_basic_add();
        logic [DW-1:0] v;
        logic [DW-1:0] exp [4] = '{8'h30, 8'h01, 8'h02, 8'h00};
        int sels [4] = '{0, 1, 5, 6};
        do_op(1, 0, 0, 'h42);
        do_op(0, 1, 0, 0);
        do_op(1, 0, 0, 'hEE);
        do_op(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            read_sel(sels[i], v);
            tests_run++;
            if (v !== exp[i]) begin
                failed++;
                $display("FAIL basic_sel%0d got=%h exp=%h", sels[i], v, exp[i]);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [DW-1:0] v;
        logic [DW-1:0] exp [4] = '{8'h2C, 8'h01, 8'h2C, 8'h01};
        int sels [4] = '{0, 1, 5, 6};
        do_op(0, 0, 1, 0);
        do_op(1, 0, 0, 'h01);
        load = 0; add = 1; clear = 0;
        repeat (300) begin
            @(posedge clock); #1;
            m_step(0, 1, 0, 0);
        end
        add = 0;
        for (int i = 0; i < 4; i++) begin
            read_sel(sels[i], v);
            tests_run++;
            if (v !== exp[i]) begin
                failed++;
                $display("FAIL cntwrap_sel%0d got=%h exp=%h", sels[i], v, exp[i]);
            end
        end
    endtask

    task automatic test_load_add_overlap();
        logic [DW-1:0] v;
        do_op(0, 0, 1, 0);
        do_op(1, 0, 0, 'h10);
        do_op(1, 1, 0, 'h20);
        read_sel(0, v);
        tests_run++;
        if (v !== 8'h10) begin
            failed++;
            $display("FAIL overlap_first got=%h exp=10", v);
        end
        do_op(0, 1, 0, 0);
        read_sel(0, v);
        tests_run++;
        if (v !== 8'h30) begin
            failed++;
            $display("FAIL overlap_second got=%h exp=30", v);
        end
        read_sel(4, v);
        tests_run++;
        if (v !== 8'h20) begin
            failed++;
            $display("FAIL overlap_operand got=%h exp=20", v);
        end
    endtask

    task automatic test_acc_overflow();
        logic [DW-1:0] v0, v1, v6;
        logic [15:0] acc258;
`ifdef ADDACC_SATURATE_EN
        acc258 = 16'hFFFF;
`else
        acc258 = 16'h00FE;
`endif
        do_op(0, 0, 1, 0);
        do_op(1, 0, 0, 'hFF);
        repeat (257) do_op(0, 1, 0, 0);
        read_sel(0, v0);
        read_sel(1, v1);
        read_sel(6, v6);
        tests_run++;
        if ({v1, v0} !== 16'hFFFF || v6 !== 8'h01) begin
            failed++;
            $display("FAIL ovf_257 got=%h%h st=%h exp=ffff st=01", v1, v0, v6);
        end
        do_op(0, 1, 0, 0);
        read_sel(0, v0);
        read_sel(1, v1);
        read_sel(6, v6);
        tests_run++;
        if ({v1, v0} !== acc258 || v6 !== 8'h03) begin
            failed++;
            $display("FAIL ovf_258 got=%h%h st=%h exp=%h st=03", v1, v0, v6, acc258);
        end
        do_op(0, 0, 0, 0);
        read_sel(6, v6);
        tests_run++;
        if (v6 !== 8'h03) begin
            failed++;
            $display("FAIL ovf_sticky got=%h exp=03", v6);
        end
    endtask

    task automatic test_clear_priority();
        logic [DW-1:0] v;
        do_op(1, 1, 1, 'h5A);
        read_sel(0, v);
        tests_run++;
        if (v !== 8'h00) begin
            failed++;
            $display("FAIL clear_acc got=%h exp=00", v);
        end
        read_sel(4, v);
        tests_run++;
        if (v !== 8'h5A) begin
            failed++;
            $display("FAIL clear_operand got=%h exp=5a", v);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        int l, a, c, d, s;
        for (int i = 0; i < 600; i++) begin
            l = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            d = $urandom_range(0, 255);
            s = $urandom_range(0, 7);
            e = m_out(s);
            load = l[0]; add = a[0]; clear = c[0];
            data_in = DW'(d); output_sel = 3'(s);
            @(posedge clock); #1;
            m_step(l[0], a[0], c[0], d);
            tests_run++;
            if (data_out !== e) begin
                failed++;
                $display("FAIL random_%0d sel=%0d got=%h exp=%h", i, s, data_out, e);
            end
        end
        load = 0; add = 0; clear = 0;
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] v;
        do_op(0, 0, 1, 0);
        do_op(1, 0, 0, 'h33);
        output_sel = 3'd0;
        add = 1;
        repeat (3) @(posedge clock);
        #3;
        reset_n = 0;
        #1;
        tests_run++;
        if (data_out !== 8'h00) begin
            failed++;
            $display("FAIL async_rst_out got=%h exp=00", data_out);
        end
        m_reset();
        @(posedge clock);
        #3;
        reset_n = 1;
        add = 0;
        for (int s = 0; s < 6; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== 8'h00) begin
                failed++;
                $display("FAIL async_rst_sel%0d got=%h exp=00", s, v);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic_add();
        test_count_wrap();
        test_load_add_overlap();
        test_acc_overflow();
        test_clear_priority();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
